multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage, directly downstream of the opcode/ALU-op decode minterms. Decode raises a one-cycle `ctrl_MULT` or `ctrl_DIV` when OP = 00000 and ALUOP = 00110 or 00111. The unit latches the operands, runs a 32-step shift-add multiply or a restoring divide, and returns a one-cycle ready pulse with result and exception flag. The pipeline stalls on `busy` until that pulse arrives.

---
 rtl/multdiv_pkg.sv | 15 +
 rtl/twos_abs.sv | 12 +
 rtl/multdiv_unit.sv | 119 +++++++++++
 tb/tb_multdiv_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/twos_abs.sv
// rtl/twos_abs.sv - conditional two's-complement negate; with negate tied to the MSB it yields the magnitude
module twos_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed 32-bit shift-add multiply / restoring divide
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     divisor;
  logic                 neg_res;

  logic                 start_mul, start_div;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, step_next;
  logic [2*WIDTH-1:0]   fin_in, fin_out;
  logic                 mul_exc, div_exc;

  assign start_mul = ctrl_MULT & ~ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;

  twos_abs #(.W(WIDTH)) u_abs_a (
    .value  (data_operandA),
    .negate (data_operandA[WIDTH-1]),
    .result (abs_a)
  );

  twos_abs #(.W(WIDTH)) u_abs_b (
    .value  (data_operandB),
    .negate (data_operandB[WIDTH-1]),
    .result (abs_b)
  );

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend shifting out / quotient shifting in}.
  // The remainder stays below 2^31, so dropping its top bit on the shift loses nothing.
  assign div_shift = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {1'b0, divisor};
  assign div_next  = div_diff[WIDTH] ? {div_shift, acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign step_next = (state == MUL) ? mul_next : div_next;
  assign fin_in    = (state == MUL) ? step_next : {{WIDTH{1'b0}}, step_next[WIDTH-1:0]};

  twos_abs #(.W(2*WIDTH)) u_res (
    .value  (fin_in),
    .negate (neg_res),
    .result (fin_out)
  );

  assign mul_exc = ~((&fin_out[2*WIDTH-1:WIDTH-1]) | ~(|fin_out[2*WIDTH-1:WIDTH-1]));
  // Only INT_MIN / -1 yields a positive quotient magnitude of 2^31.
  assign div_exc = (step_next[WIDTH-1:0] == INT_MIN) & ~neg_res;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      divisor        <= '0;
      neg_res        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start_mul || start_div) begin
        cnt     <= '0;
        neg_res <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        if (start_div && data_operandB == '0) begin
          state          <= DONE;
          busy           <= 1'b0;
          data_result    <= '0;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
        end else begin
          state   <= start_mul ? MUL : DIV;
          busy    <= 1'b1;
          acc     <= {{WIDTH{1'b0}}, (start_mul ? abs_b : abs_a)};
          divisor <= start_mul ? abs_a : abs_b;
        end
      end else begin
        case (state)
          MUL, DIV: begin
            acc <= step_next;
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              data_result    <= fin_out[WIDTH-1:0];
              data_exception <= (state == MUL) ? mul_exc : div_exc;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - scoreboard bench for multdiv_unit with a signed-arithmetic reference model
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected response from plain 64-bit signed arithmetic; 'now' is the cycle the ctrl is driven in.
  function automatic exp_t model(input bit is_mul, input logic [31:0] x, input logic [31:0] y, input int now);
    exp_t   e;
    longint sx, sy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (is_mul) begin
      p     = sx * sy;
      e.res = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
      e.due = now + 33;
    end else if (y == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
      e.due = now + 1;
    end else begin
      p     = sx / sy;
      e.res = p[31:0];
      e.exc = (p > 64'sd2147483647);
      e.due = now + 33;
    end
    return e;
  endfunction

  // A new start aborts any operation whose result has not yet been presented.
  task automatic issue(input bit m, input bit d, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = x;
    data_operandB = y;
    if (m ^ d) begin
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      q.push_back(model(m, x, y, cyc));
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() > 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (data_resultRDY === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy actual=1 required=0 (cycle %0d, result %h)", cyc, data_result);
      end else begin
        e = q.pop_front();
        check("result", 64'(data_result), 64'(e.res));
        check("exception", 64'(data_exception), 64'(e.exc));
        check("rdy_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    bit          m;
    int          sel;

    repeat (3) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exception", 64'(data_exception), 64'd0);
    reset_n = 1'b1;

    issue(1, 0, 32'h0000_0007, 32'hFFFF_FFFD);
    check("busy_in_mul", 64'(busy), 64'd1);
    wait_idle();
    repeat (3) @(negedge clock);
    check("result_held", 64'(data_result), 64'hFFFF_FFEB);
    check("busy_after_done", 64'(busy), 64'd0);

    issue(1, 0, 32'h0001_0000, 32'h0001_0000); wait_idle();
    issue(1, 0, 32'h7FFF_FFFF, 32'h0000_0001); wait_idle();
    issue(0, 1, 32'hFFFF_FFF9, 32'h0000_0002); wait_idle();
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();

    issue(0, 1, 32'd5, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("div0_busy", 64'(busy), 64'd0);
      @(negedge clock);
    end
    wait_idle();

    issue(1, 0, 32'd3, 32'd4);
    repeat (8) @(negedge clock);
    issue(0, 1, 32'd100, 32'd7);
    wait_idle();

    issue(1, 1, 32'd9, 32'd9);
    for (int i = 0; i < 4; i++) begin
      check("both_busy", 64'(busy), 64'd0);
      @(negedge clock);
    end

    // Restart in the DONE cycle: old RDY still appears, new one follows.
    issue(1, 0, 32'hFFFF_FF00, 32'd12);
    repeat (31) @(negedge clock);
    issue(0, 1, 32'hFFFF_FF9C, 32'd9);
    wait_idle();

    issue(1, 0, 32'd1234, 32'd5678);
    repeat (18) @(negedge clock);
    reset_n = 1'b0;
    q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_result", 64'(data_result), 64'd0);
    check("midreset_exception", 64'(data_exception), 64'd0);
    repeat (40) @(negedge clock);
    issue(1, 0, 32'd2, 32'd2);
    wait_idle();

    for (int n = 0; n < 80; n++) begin
      m   = ($urandom_range(0, 1) == 1);
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) y = 32'd0;
      if (sel == 1) x = 32'h8000_0000;
      if (sel == 2) y = 32'hFFFF_FFFF;
      if (sel == 3) y = 32'(int'($urandom_range(0, 20)) - 10);
      issue(m, !m, x, y);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 40)) @(negedge clock);
      else wait_idle();
    end
    wait_idle();
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
